// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: FSM state encoding,
// the ID/EX control-vector layout and the syscall halt-word constants.
package pipe_pkg;

    // Occupancy/mode of a stage buffer.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ONE    = 2'd1,
        TWO    = 2'd2,
        HALTED = 2'd3
    } stage_state_e;

    // Payload value and control bit used for the syscall-driven halt word.
    localparam int SYSCALL_HALT_CODE = 10;
    localparam int CTRL_SYSCALL_BIT  = 0;

    // Default width of the ID/EX control vector.
    localparam int ID_EX_CTRL_W = 16;

    // ID/EX control vector layout; bit 0 marks a syscall-sourced word.
    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] alu_op;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic       syscall;
    } id_ex_ctrl_t;

    // Control vector carried by the halt word: only the syscall marker set.
    function automatic logic [ID_EX_CTRL_W-1:0] halt_ctrl_word();
        return ID_EX_CTRL_W'(1) << CTRL_SYSCALL_BIT;
    endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of a stage buffer: payload, control vector and valid bit.
// Priority inside the slot: rst > force_en > clear > load. A cleared slot
// holds all-zero payload and control so it always reads as a NOP bubble.
module pipe_stage_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              force_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] force_data,
    input  logic [CTRL_W-1:0] force_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CTRL_W-1:0] ctrl_reg;

    // Slot register: reset, forced halt word, bubble clear, or normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
        end else if (force_en) begin
            valid_reg <= 1'b1;
            data_reg  <= force_data;
            ctrl_reg  <= force_ctrl;
        end else if (clear) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            ctrl_reg  <= load_ctrl;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage boundary with a 2-entry skid buffer, flush (bubble
// insertion) and sticky halt-word injection. in_ready is a function of
// registered state only, so there is no combinational ready path upstream.
// Optional feature macro: PIPE_STAGE_PERF_EN adds stall/bubble counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 128,
    parameter int                CTRL_W    = 16,
    parameter logic [DATA_W-1:0] HALT_DATA = DATA_W'(SYSCALL_HALT_CODE),
    parameter logic [CTRL_W-1:0] HALT_CTRL = CTRL_W'(1) << CTRL_SYSCALL_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              halted
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    stage_state_e state_reg;
    stage_state_e state_next;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              main_load;
    logic              main_from_skid;
    logic              main_clear;
    logic              main_force;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] main_load_data;
    logic [CTRL_W-1:0] main_load_ctrl;

    logic accept;
    logic emit;

    // Ready and halted come straight from the state register.
    assign halted   = (state_reg == HALTED);
    assign in_ready = (state_reg == EMPTY) || (state_reg == ONE);

    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : '0;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // When draining TWO the main slot refills from the skid, otherwise from upstream.
    assign main_load_data = main_from_skid ? skid_data : in_data;
    assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    // State register; rst overrides halt and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and slot control: halt (sticky) > flush > normal handshake.
    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        main_force     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if ((state_reg == HALTED) || halt) begin
            // Halt word is re-presented every cycle, emitted or not.
            state_next = HALTED;
            main_force = 1'b1;
            skid_clear = 1'b1;
        end else if (flush) begin
            // Any word accepted this cycle is dropped along with held ones.
            state_next = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        skid_load  = 1'b1;
                        state_next = TWO;
                    end else if (!accept && emit) begin
                        main_clear = 1'b1;
                        state_next = EMPTY;
                    end else if (accept && emit) begin
                        main_load  = 1'b1;
                        state_next = ONE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain case exists.
                    if (emit) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .clear      (main_clear),
        .force_en   (main_force),
        .load_data  (main_load_data),
        .load_ctrl  (main_load_ctrl),
        .force_data (HALT_DATA),
        .force_ctrl (HALT_CTRL),
        .valid      (main_valid),
        .data       (main_data),
        .ctrl       (main_ctrl)
    );

    pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear      (skid_clear),
        .force_en   (1'b0),
        .load_data  (in_data),
        .load_ctrl  (in_ctrl),
        .force_data ('0),
        .force_ctrl ('0),
        .valid      (skid_valid),
        .data       (skid_data),
        .ctrl       (skid_ctrl)
    );

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] bubble_cnt_reg;
    logic        flush_drop;
    logic [31:0] bubble_inc;

    // A flush counts as a bubble only if it actually throws away a word.
    assign flush_drop = flush && !halt && (state_reg != HALTED) &&
                        ((main_valid && !out_ready) || skid_valid || accept);
    assign bubble_inc = 32'(!out_valid && !halted) + 32'(flush_drop);

    // Free-running performance counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            bubble_cnt_reg <= bubble_cnt_reg + bubble_inc;
        end
    end

    assign stall_cnt  = stall_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (default parameters).
// Inputs change 1 time unit after posedge; outputs are checked at that point.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              halt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              halted;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
    logic [31:0]       bubble_base;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .halt      (halt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .halted    (halted)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [127:0] d,
                             input logic [15:0] c, input logic rdy, input logic h);
        check({tag, ".valid"},  128'(out_valid), 128'(v));
        check({tag, ".data"},   128'(out_data),  d);
        check({tag, ".ctrl"},   128'(out_ctrl),  128'(c));
        check({tag, ".ready"},  128'(in_ready),  128'(rdy));
        check({tag, ".halted"}, 128'(halted),    128'(h));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        flush = 1'b0; halt = 1'b0; out_ready = 1'b0;
        #1;
        do_reset();
        check_out("reset", 1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

        // Stream 1..8 with downstream always ready: one word per cycle.
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = 128'(k);
            in_ctrl  = 16'(k + 'h100);
            tick();
            check_out($sformatf("stream%0d", k), 1'b1, 128'(k), 16'(k + 'h100), 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        tick();
        check_out("stream_drain", 1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

        // Backpressure: A then B fill both slots, B must follow A.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 128'h11; in_ctrl = 16'h5;
        tick();
        check_out("bp_one", 1'b1, 128'h11, 16'h5, 1'b1, 1'b0);
        in_data = 128'h22; in_ctrl = 16'h6;
        tick();
        check_out("bp_two", 1'b1, 128'h11, 16'h5, 1'b0, 1'b0);
        in_data = 128'h99; in_ctrl = 16'h9;
        tick();
        check_out("bp_hold", 1'b1, 128'h11, 16'h5, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_out("bp_rel_b", 1'b1, 128'h22, 16'h6, 1'b1, 1'b0);
        tick();
        check_out("bp_empty", 1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

        // Flush while TWO with C=0x33 offered: everything vanishes.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'h44; in_ctrl = 16'h4; tick();
        in_data = 128'h55; in_ctrl = 16'h7; tick();
        check_out("fl_two", 1'b1, 128'h44, 16'h4, 1'b0, 1'b0);
        in_data = 128'h33; in_ctrl = 16'h3; flush = 1'b1;
        tick();
        check_out("fl_next", 1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("fl_noc%0d", k), 128'(out_valid), 128'(0));
        end

        // Flush in ONE with a simultaneous accept: the new word is dropped.
        in_valid = 1'b1; in_data = 128'h66; in_ctrl = 16'h2; tick();
        in_data = 128'h77; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check_out("fl_acc", 1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
        tick();
        check("fl_acc_gone", 128'(out_valid), 128'(0));

        // Halt together with flush in ONE: halt wins and is sticky.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h12; in_ctrl = 16'h8; tick();
        in_valid = 1'b0; halt = 1'b1; flush = 1'b1;
        tick();
        halt = 1'b0; flush = 1'b0;
        check_out("halt", 1'b1, 128'd10, 16'h1, 1'b0, 1'b1);
        flush = 1'b1; tick(); flush = 1'b0;
        check_out("halt_fl", 1'b1, 128'd10, 16'h1, 1'b0, 1'b1);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 128'h13; tick();
        check_out("halt_emit", 1'b1, 128'd10, 16'h1, 1'b0, 1'b1);
        in_valid = 1'b0;

        // Reset while halted with downstream stalled.
        out_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("rst_halt", 1'b0, 128'h0, 16'h0, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 128'hAB; in_ctrl = 16'hC; out_ready = 1'b1;
        tick();
        check_out("post_rst", 1'b1, 128'hAB, 16'hC, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        check_out("post_rst_e", 1'b0, 128'h0, 16'h0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        // Counters: 3 stall cycles, then flush of the held word.
        do_reset();
        check("perf_rst_stall", 128'(stall_cnt), 128'(0));
        out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h5A; in_ctrl = 16'h1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("perf_stall3", 128'(stall_cnt), 128'(3));
        bubble_base = bubble_cnt;
        flush = 1'b1; tick(); flush = 1'b0;
        check("perf_stall_fl", 128'(stall_cnt), 128'(4));
        check("perf_bub_fl", 128'(bubble_cnt), 128'(bubble_base + 32'd1));
        tick(); tick();
        check("perf_bub_idle", 128'(bubble_cnt), 128'(bubble_base + 32'd3));
        check("perf_stall_idle", 128'(stall_cnt), 128'(4));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
